// File: rtl/program_loader.sv
// Assembles 32-bit little-endian words from a framed byte stream and writes them into instruction memory.
// Takes one byte per cycle. Each word write is registered on the 4th byte of the word. in_ready is low in DONE and ERR and while reset is low. The optional CHK byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state;
  logic              rdy_q;
  logic [7:0]        len_hi;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       word_q;
  logic [15:0]       len_n;
  logic              take;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk;
`endif

  assign in_ready = reset && rdy_q;
  assign take     = in_valid && in_ready;
  assign len_n    = {len_hi, in_data};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      rdy_q    <= 1'b1;
      len_hi   <= 8'd0;
      word_idx <= '0;
      last_idx <= '0;
      byte_idx <= 2'd0;
      word_q   <= 24'd0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= 32'd0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk      <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take && in_data == SYNC_BYTE) state <= S_LEN_HI;
        end
        S_LEN_HI: begin
          if (take) begin
            len_hi <= in_data;
`ifdef LOADER_CHECKSUM_EN
            chk    <= chk ^ in_data;
`endif
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (take) begin
`ifdef LOADER_CHECKSUM_EN
            chk      <= chk ^ in_data;
`endif
            word_idx <= '0;
            byte_idx <= 2'd0;
            last_idx <= ADDR_W'(len_n - 16'd1);
            if (len_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= S_CHK;
`else
              state    <= S_DONE;
              rdy_q    <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else if (32'(len_n) > MAX_WORDS) begin
              state <= S_ERR;
              rdy_q <= 1'b0;
              error <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
`ifdef LOADER_CHECKSUM_EN
            chk      <= chk ^ in_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            word_q   <= {in_data, word_q[23:8]};
            // Fourth byte completes the word; it goes straight to memory, not through word_q.
            if (byte_idx == 2'd3) begin
              mem_we   <= 1'b1;
              mem_addr <= word_idx;
              mem_wd   <= {in_data, word_q};
              word_idx <= word_idx + ADDR_W'(1);
              if (word_idx == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
                state    <= S_CHK;
`else
                state    <= S_DONE;
                rdy_q    <= 1'b0;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (take) begin
            rdy_q <= 1'b0;
            if (in_data == chk) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERR: begin
          if (restart) begin
            state    <= S_IDLE;
            rdy_q    <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            word_idx <= '0;
            byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            chk      <= 8'd0;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table vectors, hand sequences, randomized frames against a frame-parsing model.
module tb_program_loader;

  localparam int ADDR_W = 8;
  localparam int MAXW   = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              restart = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic              cpu_hold;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wd);
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: parse a byte stream by the frame rules.
  logic [7:0]  tx[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_err;

  function automatic void model();
    int i, n;
    logic [7:0] c;
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b0; exp_err = 1'b0;
    i = 0;
    while (i < tx.size() && tx[i] != 8'hA5) i++;
    if (i + 2 >= tx.size()) return;
    n = int'({tx[i+1], tx[i+2]});
    c = tx[i+1] ^ tx[i+2];
    i += 3;
    if (n > MAXW) begin exp_err = 1'b1; return; end
    for (int w = 0; w < n; w++) begin
      if (i + 4 > tx.size()) return;
      exp_addr.push_back(w);
      exp_data.push_back({tx[i+3], tx[i+2], tx[i+1], tx[i]});
      c = c ^ tx[i] ^ tx[i+1] ^ tx[i+2] ^ tx[i+3];
      i += 4;
    end
`ifdef LOADER_CHECKSUM_EN
    if (i < tx.size()) begin
      exp_done = (tx[i] == c);
      exp_err  = !exp_done;
    end
`else
    exp_done = 1'b1;
`endif
  endfunction

  task automatic send(input bit gaps);
    int t;
    foreach (tx[k]) begin
      @(negedge clk);
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_data  = tx[k];
      in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) begin
        nvec++; nerr++;
        $display("FAIL send_timeout: byte %0d never accepted, in_ready=%b", k, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clr();
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic pulse_restart(input string tag);
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    check({tag, "_rs_error"},    32'(error),    32'd0);
    check({tag, "_rs_done"},     32'(done),     32'd0);
    check({tag, "_rs_hold"},     32'(cpu_hold), 32'd1);
    check({tag, "_rs_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic finish_check(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
    check({tag, "_done"},     32'(done),     32'(exp_done));
    check({tag, "_error"},    32'(error),    32'(exp_err));
    check({tag, "_hold"},     32'(cpu_hold), 32'(!exp_done));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(!(exp_done || exp_err)));
  endtask

  typedef struct {
    logic [127:0] b;
    int           nb;
    int           nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic         d;
    logic         e;
  } vec_t;

  vec_t tbl[4];
  int   ntbl;

  initial begin
    logic [7:0] c, x;
    int n;
    logic [31:0] w;

`ifdef LOADER_CHECKSUM_EN
    tbl[0] = '{b: {8'h00, 8'h37, 8'hA5, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28, 16'h0},
               nb: 14, nw: 2, w0: 32'h12345678, w1: 32'hDEADBEEF, d: 1'b1, e: 1'b0};
    tbl[1] = '{b: {8'h00, 8'h37, 8'hA5, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h03, 16'h0},
               nb: 14, nw: 2, w0: 32'h12345678, w1: 32'hDEADBEEF, d: 1'b0, e: 1'b1};
    tbl[2] = '{b: {8'hA5, 8'h01, 8'h01, 104'h0}, nb: 3, nw: 0, w0: 32'h0, w1: 32'h0, d: 1'b0, e: 1'b1};
    tbl[3] = '{b: {8'hA5, 8'h00, 8'h00, 8'h00, 96'h0}, nb: 4, nw: 0, w0: 32'h0, w1: 32'h0, d: 1'b1, e: 1'b0};
    ntbl = 4;
`else
    tbl[0] = '{b: {8'h00, 8'h37, 8'hA5, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 24'h0},
               nb: 13, nw: 2, w0: 32'h12345678, w1: 32'hDEADBEEF, d: 1'b1, e: 1'b0};
    tbl[1] = '{b: {8'hA5, 8'h01, 8'h01, 104'h0}, nb: 3, nw: 0, w0: 32'h0, w1: 32'h0, d: 1'b0, e: 1'b1};
    tbl[2] = '{b: {8'hA5, 8'h00, 8'h00, 104'h0}, nb: 3, nw: 0, w0: 32'h0, w1: 32'h0, d: 1'b1, e: 1'b0};
    tbl[3] = tbl[2];
    ntbl = 3;
`endif

    // Reset state.
    do_reset();
    clr();
    @(negedge clk);
    check("rst_hold",     32'(cpu_hold), 32'd1);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_we",       32'(mem_we),   32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_addr",     32'(mem_addr), 32'd0);

    // Table vectors.
    for (int i = 0; i < ntbl; i++) begin
      do_reset();
      clr();
      tx.delete();
      for (int j = 0; j < tbl[i].nb; j++) tx.push_back(tbl[i].b[127-8*j -: 8]);
      send(1'b0);
      repeat (3) @(negedge clk);
      check($sformatf("tbl%0d_nwrites", i), 32'(got_data.size()), 32'(tbl[i].nw));
      if (tbl[i].nw > 0 && got_data.size() > 0) begin
        check($sformatf("tbl%0d_addr0", i), 32'(got_addr[0]), 32'd0);
        check($sformatf("tbl%0d_data0", i), got_data[0], tbl[i].w0);
      end
      if (tbl[i].nw > 1 && got_data.size() > 1) begin
        check($sformatf("tbl%0d_addr1", i), 32'(got_addr[1]), 32'd1);
        check($sformatf("tbl%0d_data1", i), got_data[1], tbl[i].w1);
      end
      check($sformatf("tbl%0d_done", i),     32'(done),     32'(tbl[i].d));
      check($sformatf("tbl%0d_error", i),    32'(error),    32'(tbl[i].e));
      check($sformatf("tbl%0d_hold", i),     32'(cpu_hold), 32'(!tbl[i].d));
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd0);
      if (tbl[i].e) pulse_restart($sformatf("tbl%0d", i));
    end

    // Reset in the middle of word 1: only word 0 survives, loader back in IDLE.
    do_reset();
    clr();
    tx.delete();
    tx.push_back(8'hA5); tx.push_back(8'h00); tx.push_back(8'h02);
    for (int j = 0; j < 6; j++) tx.push_back(8'($urandom_range(0, 255)));
    w = {tx[6], tx[5], tx[4], tx[3]};
    send(1'b1);
    do_reset();
    repeat (2) @(negedge clk);
    check("midrst_nwrites", 32'(got_data.size()), 32'd1);
    if (got_data.size() > 0) begin
      check("midrst_addr0", 32'(got_addr[0]), 32'd0);
      check("midrst_data0", got_data[0], w);
    end
    check("midrst_hold",     32'(cpu_hold), 32'd1);
    check("midrst_done",     32'(done),     32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);

    // Randomized frames, last one at full capacity.
    clr();
    for (int f = 0; f < 10; f++) begin
      tx.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        x = 8'($urandom_range(0, 255));
        if (x == 8'hA5) x = 8'h00;
        tx.push_back(x);
      end
      n = (f == 9) ? MAXW : int'($urandom_range(1, 6));
      tx.push_back(8'hA5);
      tx.push_back(8'(n >> 8));
      tx.push_back(8'(n));
      c = 8'(n >> 8) ^ 8'(n);
      for (int j = 0; j < 4 * n; j++) begin
        x = 8'($urandom_range(0, 255));
        tx.push_back(x);
        c = c ^ x;
      end
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      tx.push_back(c);
`endif
      model();
      send(1'b1);
      finish_check($sformatf("rnd%0d", f));
      clr();
      if (done === 1'b1 || error === 1'b1) pulse_restart($sformatf("rnd%0d", f));
      else do_reset();
      clr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
